// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mdu_pkg
// Purpose : Shared op encoding and FSM state type for the multiply/divide unit
// Revision: 1.0
// ============================================================================
package mdu_pkg;

  // One-hot op vector width and bit positions
  localparam int MDOP_W   = 8;
  localparam int MD_MULT  = 0;
  localparam int MD_MULTU = 1;
  localparam int MD_DIV   = 2;
  localparam int MD_DIVU  = 3;
  localparam int MD_MTHI  = 4;
  localparam int MD_MTLO  = 5;
  localparam int MD_MFHI  = 6;
  localparam int MD_MFLO  = 7;

  typedef logic [MDOP_W-1:0] mdop_t;

  // Unit occupancy state
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_t;

endpackage
`default_nettype wire

// File: rtl/mdu_div.sv
`default_nettype none
// ============================================================================
// Module  : mdu_div
// Purpose : 32-step iterative restoring divider on unsigned magnitudes.
//           start loads the operands, one iteration per clock afterwards,
//           done flags the 32nd (last) iteration, abort drops the operation.
// Revision: 1.0
// ============================================================================
module mdu_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [63:0] rq;      // {partial remainder, dividend bits / quotient bits}
  logic [31:0] dvsr;
  logic [5:0]  count;
  logic        busy;
  logic [32:0] upper;   // partial remainder after the left shift (33 bits)
  logic [32:0] diff;

  assign upper     = rq[63:31];
  assign diff      = upper - {1'b0, dvsr};
  assign done      = busy && (count == 6'd31);
  assign quotient  = rq[31:0];
  assign remainder = rq[63:32];

  // Load on start, then shift-subtract once per cycle until 32 iterations are done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq    <= 64'd0;
      dvsr  <= 32'd0;
      count <= 6'd0;
      busy  <= 1'b0;
    end else if (abort) begin
      busy  <= 1'b0;
    end else if (start) begin
      rq    <= {32'd0, dividend};
      dvsr  <= divisor;
      count <= 6'd0;
      busy  <= 1'b1;
    end else if (busy) begin
      count <= count + 6'd1;
      if (done) busy <= 1'b0;
      // A borrow means the shifted remainder is below the divisor: restore
      if (diff[32]) rq <= {upper[31:0], rq[30:0], 1'b0};
      else          rq <= {diff[31:0],  rq[30:0], 1'b1};
    end
  end

endmodule
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module  : mdu
// Purpose : Multiply/divide unit beside execute. Owns HI/LO, single busy
//           cycle MULT/MULTU, 33-cycle DIV/DIVU, MTHI/MTLO writes and the
//           MFHI/MFLO read path with in-flight product bypass.
// Revision: 1.0
// ============================================================================
module mdu
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mdu_en_i,
  input  logic        mdu_flush_i,
  input  logic [31:0] mdu_opr1_i,
  input  logic [31:0] mdu_opr2_i,
  input  mdop_t       mduop_i,
  input  logic [31:0] mdu_whi_i,
  input  logic [31:0] mdu_wlo_i,
  output logic        mdu_is_active,
  output logic        mdu_div_active,
  output logic [31:0] mdu_hi_o,
  output logic [31:0] mdu_lo_o
);

  mdu_state_t  state, state_nxt;
  logic [31:0] hi_q, lo_q, hi_d, lo_d;
  logic        hi_we, lo_we;
  logic [31:0] mul_a, mul_b;
  logic        mul_sgn;
  logic        neg_q, neg_r;

  // Acceptance. FIX is the completion edge of a divide, so (like MUL) a new
  // op may be taken on it; only the iterating DIV state refuses ops.
  logic op_accept, is_mul, is_div, is_mthi, is_mtlo, div_sgn;
  assign op_accept = mdu_en_i && !mdu_flush_i && (|mduop_i) && (state != ST_DIV);
  assign is_mul    = op_accept && (mduop_i[MD_MULT] || mduop_i[MD_MULTU]);
  assign is_div    = op_accept && (mduop_i[MD_DIV]  || mduop_i[MD_DIVU]);
  assign is_mthi   = op_accept && mduop_i[MD_MTHI];
  assign is_mtlo   = op_accept && mduop_i[MD_MTLO];
  assign div_sgn   = mduop_i[MD_DIV];

  // Product: sign-extend to 64 bits; the low 64 bits of the wide product are
  // the correct result for both signed and unsigned operands.
  logic [63:0] prod;
  assign prod = {{32{mul_sgn & mul_a[31]}}, mul_a} * {{32{mul_sgn & mul_b[31]}}, mul_b};

  // Divider works on magnitudes; signs are restored in FIX
  logic [31:0] dvd_abs, dvs_abs;
  logic        div_done;
  logic [31:0] quot, rem, quot_fix, rem_fix;
  assign dvd_abs  = (div_sgn && mdu_opr1_i[31]) ? (32'd0 - mdu_opr1_i) : mdu_opr1_i;
  assign dvs_abs  = (div_sgn && mdu_opr2_i[31]) ? (32'd0 - mdu_opr2_i) : mdu_opr2_i;
  assign quot_fix = neg_q ? (32'd0 - quot) : quot;
  assign rem_fix  = neg_r ? (32'd0 - rem)  : rem;

  mdu_div u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (is_div),
    .abort     (mdu_flush_i),
    .dividend  (dvd_abs),
    .divisor   (dvs_abs),
    .done      (div_done),
    .quotient  (quot),
    .remainder (rem)
  );

  // Next state and HI/LO write selection; a younger MTHI/MTLO overrides a completing result
  always_comb begin
    state_nxt = state;
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state)
      ST_MUL: begin
        state_nxt = ST_IDLE;
        if (!mdu_flush_i) begin
          hi_we = 1'b1;
          lo_we = 1'b1;
          hi_d  = prod[63:32];
          lo_d  = prod[31:0];
        end
      end
      ST_DIV: begin
        if (mdu_flush_i)   state_nxt = ST_IDLE;
        else if (div_done) state_nxt = ST_FIX;
      end
      ST_FIX: begin
        state_nxt = ST_IDLE;
        if (!mdu_flush_i) begin
          hi_we = 1'b1;
          lo_we = 1'b1;
          hi_d  = rem_fix;
          lo_d  = quot_fix;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (is_mul)      state_nxt = ST_MUL;
    else if (is_div) state_nxt = ST_DIV;
    if (is_mthi) begin
      hi_we = 1'b1;
      hi_d  = mdu_whi_i;
    end
    if (is_mtlo) begin
      lo_we = 1'b1;
      lo_d  = mdu_wlo_i;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Latch multiply operands and divide sign flags on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a   <= 32'd0;
      mul_b   <= 32'd0;
      mul_sgn <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else begin
      if (is_mul) begin
        mul_a   <= mdu_opr1_i;
        mul_b   <= mdu_opr2_i;
        mul_sgn <= mduop_i[MD_MULT];
      end
      if (is_div) begin
        neg_q <= div_sgn & (mdu_opr1_i[31] ^ mdu_opr2_i[31]);
        neg_r <= div_sgn & mdu_opr1_i[31];
      end
    end
  end

  // Architectural HI/LO registers with write enables
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      if (hi_we) hi_q <= hi_d;
      if (lo_we) lo_q <= lo_d;
    end
  end

  assign mdu_is_active  = (state != ST_IDLE);
  assign mdu_div_active = (state == ST_DIV) || (state == ST_FIX);
  assign mdu_hi_o       = (state == ST_MUL) ? prod[63:32] : hi_q;
  assign mdu_lo_o       = (state == ST_MUL) ? prod[31:0]  : lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
// Module  : tb_mdu
// Purpose : Scoreboard bench for mdu. Stimulus pushes per-cycle expectations
//           from an arithmetic reference model; a negedge monitor pops and
//           compares them against the DUT outputs.
// Revision: 1.0
// ============================================================================
module tb_mdu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mdu_en = 1'b0;
  logic        mdu_flush = 1'b0;
  logic [31:0] opr1 = '0, opr2 = '0, whi = '0, wlo = '0;
  logic [7:0]  op = '0;
  logic        is_active, div_active;
  logic [31:0] hi_o, lo_o;

  always #5 clk = ~clk;

  mdu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mdu_en_i       (mdu_en),
    .mdu_flush_i    (mdu_flush),
    .mdu_opr1_i     (opr1),
    .mdu_opr2_i     (opr2),
    .mduop_i        (op),
    .mdu_whi_i      (whi),
    .mdu_wlo_i      (wlo),
    .mdu_is_active  (is_active),
    .mdu_div_active (div_active),
    .mdu_hi_o       (hi_o),
    .mdu_lo_o       (lo_o)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        act;
    logic        dact;
    string       name;
  } exp_t;
  exp_t sbq[$];

  logic [31:0] m_hi = '0, m_lo = '0;

  task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %08h expected %08h", nm, cyc, got, exp);
    end
  endtask

  // Monitor: compare every expectation whose cycle has come
  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s: expectation for cyc %0d missed (now %0d)", e.name, e.cyc, cyc);
      end else begin
        chk32({e.name, ".hi"},   hi_o, e.hi);
        chk32({e.name, ".lo"},   lo_o, e.lo);
        chk32({e.name, ".act"},  {31'd0, is_active},  {31'd0, e.act});
        chk32({e.name, ".dact"}, {31'd0, div_active}, {31'd0, e.dact});
      end
    end
  end

  // Execute never presents an op while a divide iterates; only the FIX cycle (33rd) may
  int dcnt = 0;
  always @(negedge clk) begin
    if (div_active) dcnt++;
    else            dcnt = 0;
    assert (!(rst_n && div_active && mdu_en && !mdu_flush && op != 8'd0 && dcnt != 33))
      else $error("op presented while divide iterating (cyc %0d)", cyc);
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_mul(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint p;
    logic [63:0] u;
    if (sgn) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return p;
    end
    u = {32'd0, a} * {32'd0, b};
    return u;
  endfunction

  function automatic void ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, lq, lr;
    if (b == 32'd0) begin
      // Magnitude quotient is all ones; it is negated when a is negative
      q = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0];
      r  = lr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom());
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic push(input int c, input string nm, input logic act, input logic dact,
                      input logic [31:0] h, input logic [31:0] l);
    sbq.push_back('{c, h, l, act, dact, nm});
  endtask

  // Present inputs for one edge; returns #1 after that edge (cyc = that edge)
  task automatic drive(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] wh, input logic [31:0] wl, input logic en, input logic f);
    op = o; opr1 = a; opr2 = b; whi = wh; wlo = wl; mdu_en = en; mdu_flush = f;
    @(posedge clk); #1;
    op = 8'd0; mdu_flush = 1'b0; mdu_en = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_mul(input bit sgn, input logic [31:0] a, input logic [31:0] b, input bit last);
    logic [63:0] p;
    p = ref_mul(sgn, a, b);
    drive(sgn ? 8'h01 : 8'h02, a, b, 32'($urandom()), 32'($urandom()), 1'b1, 1'b0);
    push(cyc, "mul_bypass", 1'b1, 1'b0, p[63:32], p[31:0]);
    m_hi = p[63:32];
    m_lo = p[31:0];
    if (last) begin
      push(cyc + 1, "mul_write", 1'b0, 1'b0, m_hi, m_lo);
      idle(1);
    end
  endtask

  task automatic do_div(input bit sgn, input logic [31:0] a, input logic [31:0] b, input bit chain);
    int e0;
    logic [31:0] q, r;
    drive(sgn ? 8'h04 : 8'h08, a, b, 32'($urandom()), 32'($urandom()), 1'b1, 1'b0);
    e0 = cyc;
    for (int i = 0; i <= 32; i++) push(e0 + i, "div_busy", 1'b1, 1'b1, m_hi, m_lo);
    ref_div(sgn, a, b, q, r);
    m_lo = q;
    m_hi = r;
    idle(32);
    if (!chain) begin
      push(e0 + 33, "div_result", 1'b0, 1'b0, m_hi, m_lo);
      idle(1);
    end
  endtask

  task automatic do_mt(input bit to_hi, input logic [31:0] v);
    logic [31:0] other;
    other = 32'($urandom());
    if (to_hi) drive(8'h10, pick(), pick(), v, other, 1'b1, 1'b0);
    else       drive(8'h20, pick(), pick(), other, v, 1'b1, 1'b0);
    if (to_hi) m_hi = v;
    else       m_lo = v;
    push(cyc, to_hi ? "mthi" : "mtlo", 1'b0, 1'b0, m_hi, m_lo);
  endtask

  task automatic do_mf(input bit from_hi);
    drive(from_hi ? 8'h40 : 8'h80, pick(), pick(), 32'($urandom()), 32'($urandom()), 1'b1, 1'b0);
    push(cyc, from_hi ? "mfhi" : "mflo", 1'b0, 1'b0, m_hi, m_lo);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int e0;
    int w;
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mdu_en = 1'b1;
    push(cyc, "reset", 1'b0, 1'b0, 32'd0, 32'd0);
    idle(1);

    // Directed cases
    do_mul(1'b1, 32'hFFFF_FFFE, 32'd3, 1'b1);
    do_mul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_mf(1'b1);
    idle(1);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_div(1'b0, 32'd7, 32'd0, 1'b0);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // Flush during a divide: no write, back to idle one edge later
    do_mt(1'b1, 32'h1111_1111);
    do_mt(1'b0, 32'h1111_1111);
    drive(8'h04, 32'd100, 32'd7, 32'd0, 32'd0, 1'b1, 1'b0);
    e0 = cyc;
    for (int i = 0; i <= 10; i++) push(e0 + i, "flush_busy", 1'b1, 1'b1, m_hi, m_lo);
    idle(10);
    drive(8'h00, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    push(cyc, "flush_idle", 1'b0, 1'b0, m_hi, m_lo);
    idle(25);
    push(cyc, "flush_nowrite", 1'b0, 1'b0, m_hi, m_lo);
    drive(8'h01, 32'd5, 32'd6, 32'd0, 32'd0, 1'b1, 1'b1);
    push(cyc, "mul_flushed", 1'b0, 1'b0, m_hi, m_lo);
    drive(8'h01, 32'd5, 32'd6, 32'd0, 32'd0, 1'b0, 1'b0);
    push(cyc, "mul_no_en", 1'b0, 1'b0, m_hi, m_lo);
    drive(8'h10, 32'd5, 32'd6, 32'h2222_2222, 32'h3333_3333, 1'b1, 1'b1);
    push(cyc, "mt_flushed", 1'b0, 1'b0, m_hi, m_lo);

    // MTHI accepted on the MUL completion edge overrides only HI
    do_mul(1'b1, 32'h0001_2345, 32'hFFFF_0003, 1'b0);
    do_mt(1'b1, 32'h0000_ABCD);
    idle(1);

    // Earliest follow-on op lands on the FIX edge
    do_div(1'b1, 32'd1000, 32'hFFFF_FFFD, 1'b1);
    do_mt(1'b0, 32'h5555_AAAA);
    idle(1);

    // Randomized mix
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a, b;
      a = pick();
      b = pick();
      case ($urandom_range(0, 7))
        0: do_mul(1'b1, a, b, 1'($urandom_range(0, 1)));
        1: do_mul(1'b0, a, b, 1'($urandom_range(0, 1)));
        2: do_div(1'b1, a, b, 1'($urandom_range(0, 1)));
        3: do_div(1'b0, a, b, 1'($urandom_range(0, 1)));
        4: do_mt(1'b1, a);
        5: do_mt(1'b0, a);
        6: do_mf(1'b1);
        default: do_mf(1'b0);
      endcase
    end
    idle(2);
    push(cyc, "final_state", 1'b0, 1'b0, m_hi, m_lo);
    idle(2);

    // Reset asserted mid-divide clears everything without waiting for a clock
    drive(8'h04, 32'h0000_1000, 32'd3, 32'd0, 32'd0, 1'b1, 1'b0);
    e0 = cyc;
    for (int i = 0; i <= 4; i++) push(e0 + i, "pre_reset_busy", 1'b1, 1'b1, m_hi, m_lo);
    idle(5);
    #2;
    rst_n = 1'b0;
    #1;
    chk32("async_reset.hi",   hi_o, 32'd0);
    chk32("async_reset.lo",   lo_o, 32'd0);
    chk32("async_reset.act",  {31'd0, is_active},  32'd0);
    chk32("async_reset.dact", {31'd0, div_active}, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    push(cyc, "post_reset", 1'b0, 1'b0, 32'd0, 32'd0);

    // Drain the scoreboard within a bounded number of cycles
    w = 0;
    while (sbq.size() > 0 && w < 100) begin
      idle(1);
      w++;
    end
    if (sbq.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
